demux_router: RTL and testbench

DEMUX_ROUTER -- requirements
Module: demux_router

---
 rtl/demux_router.sv | 82 ++++++++
 tb/tb_demux_router.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/demux_router.sv
// One-to-four word distributor: each accepted input word is steered by select
// bits or a round-robin pointer into a one-word holding register per channel.
module demux_router #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               sbit0,
    input  logic               sbit1,
    input  logic               mode,
    output logic [4*WIDTH-1:0] out_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [7:0]         xfer_count
);

    logic [WIDTH-1:0] data_r [4];
    logic [3:0]       valid_r;
    logic [1:0]       rr_r;
    logic [7:0]       xfer_count_r;
    logic [1:0]       dest_s;
    logic             in_ready_s;
    logic             accept_s;
    logic [3:0]       load_s;

    // Destination select, back-pressure and per-channel load strobes.
    always_comb begin
        dest_s     = mode ? rr_r : {sbit1, sbit0};
        // A full channel only accepts when it is being drained on the same edge.
        in_ready_s = rst_n && (!valid_r[dest_s] || out_ready[dest_s]);
        accept_s   = in_valid && in_ready_s;
        load_s     = 4'b0000;
        if (accept_s) begin
            load_s[dest_s] = 1'b1;
        end else begin
            load_s = 4'b0000;
        end
    end

    generate
        for (genvar k = 0; k < 4; k++) begin : g_chan
            // Holding register k: fill has priority over drain, data kept after drain.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_r[k]  <= {WIDTH{1'b0}};
                    valid_r[k] <= 1'b0;
                end else if (load_s[k]) begin
                    data_r[k]  <= in_data;
                    valid_r[k] <= 1'b1;
                end else if (valid_r[k] && out_ready[k]) begin
                    valid_r[k] <= 1'b0;
                end else begin
                    valid_r[k] <= valid_r[k];
                end
            end

            assign out_data[k*WIDTH +: WIDTH] = data_r[k];
        end
    endgenerate

    // Accept counter and round-robin pointer; the pointer only moves on mode-1 accepts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_count_r <= 8'd0;
            rr_r         <= 2'd0;
        end else if (accept_s) begin
            xfer_count_r <= xfer_count_r + 8'd1;
            rr_r         <= mode ? (rr_r + 2'd1) : rr_r;
        end else begin
            xfer_count_r <= xfer_count_r;
            rr_r         <= rr_r;
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = valid_r;
    assign xfer_count = xfer_count_r;

endmodule

// File: tb/tb_demux_router.sv
// Self-checking bench for demux_router: per-channel scoreboard queues plus
// directed steps for the reference scenarios.
module tb_demux_router;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [W-1:0]   in_data = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic           sbit0 = 1'b0;
    logic           sbit1 = 1'b0;
    logic           mode = 1'b0;
    logic [4*W-1:0] out_data;
    logic [3:0]     out_valid;
    logic [3:0]     out_ready = 4'b0000;
    logic [7:0]     xfer_count;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    // Bench model state
    logic [W-1:0] exp_q [4][$];
    logic [W-1:0] last_d [4];
    logic [1:0]   m_rr;
    logic [7:0]   m_cnt;

    demux_router #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .sbit0(sbit0), .sbit1(sbit1), .mode(mode),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .xfer_count(xfer_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vec_cnt++;
        assert (got === exp) else begin
            miss_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic [1:0] s,
                         input logic m, input logic [3:0] r);
        in_valid  = v;
        in_data   = d;
        sbit0     = s[0];
        sbit1     = s[1];
        mode      = m;
        out_ready = r;
    endtask

    // Checks DUT against the model just before the next rising edge, then
    // advances the model by what that edge will do.
    task automatic monitor();
        logic [1:0] dest;
        logic       exp_rdy;
        if (!rst_n) begin
            chk("rst_out_valid", {12'd0, out_valid}, 16'h0000);
            chk("rst_in_ready", {15'd0, in_ready}, 16'h0000);
            chk("rst_xfer_count", {8'd0, xfer_count}, 16'h0000);
            chk("rst_out_data", out_data, 16'h0000);
            for (int k = 0; k < 4; k++) begin
                exp_q[k].delete();
                last_d[k] = '0;
            end
            m_rr  = 2'd0;
            m_cnt = 8'd0;
        end else begin
            dest    = mode ? m_rr : {sbit1, sbit0};
            exp_rdy = (exp_q[dest].size() == 0) || out_ready[dest];
            chk("in_ready", {15'd0, in_ready}, {15'd0, exp_rdy});
            chk("xfer_count", {8'd0, xfer_count}, {8'd0, m_cnt});
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("out_valid%0d", k), {15'd0, out_valid[k]},
                    {15'd0, (exp_q[k].size() != 0)});
                chk($sformatf("out_data%0d", k), {12'd0, out_data[k*W +: W]}, {12'd0, last_d[k]});
                if (exp_q[k].size() != 0 && out_ready[k]) begin
                    chk($sformatf("deliver%0d", k), {12'd0, out_data[k*W +: W]},
                        {12'd0, exp_q[k][0]});
                    void'(exp_q[k].pop_front());
                end
            end
            if (in_valid && exp_rdy) begin
                exp_q[dest].push_back(in_data);
                last_d[dest] = in_data;
                m_cnt = m_cnt + 8'd1;
                if (mode) m_rr = m_rr + 2'd1;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        for (int k = 0; k < 4; k++) last_d[k] = '0;
        m_rr  = 2'd0;
        m_cnt = 8'd0;

        // Reset
        #2 rst_n = 1'b0;
        #1;
        chk("reset_in_ready", {15'd0, in_ready}, 16'h0000);
        cycle();
        cycle();
        rst_n = 1'b1;

        // Mode 0, single word to ch1
        drive(1'b1, 4'hA, 2'b01, 1'b0, 4'b1111);
        cycle();
        drive(1'b0, 4'h0, 2'b00, 1'b0, 4'b1111);
        chk("v030_valid", {12'd0, out_valid}, 16'h0002);
        chk("v030_data", {12'd0, out_data[7:4]}, 16'h000A);
        chk("v030_count", {8'd0, xfer_count}, 16'h0001);
        cycle();
        chk("v030_retain", {12'd0, out_data[7:4]}, 16'h000A);

        // Stall on full ch2, then drain-and-fill on the same edge
        drive(1'b1, 4'h3, 2'b10, 1'b0, 4'b0000);
        cycle();
        drive(1'b1, 4'h5, 2'b10, 1'b0, 4'b0000);
        #1;
        chk("v031_stall", {15'd0, in_ready}, 16'h0000);
        cycle();
        out_ready = 4'b0100;
        cycle();
        chk("v031_valid2", {15'd0, out_valid[2]}, 16'h0001);
        chk("v031_data2", {12'd0, out_data[11:8]}, 16'h0005);
        drive(1'b0, 4'h0, 2'b00, 1'b0, 4'b1111);
        cycle();

        // Round-robin, back-to-back
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, W'(i), 2'b00, 1'b1, 4'b1111);
            cycle();
        end
        drive(1'b1, 4'h7, 2'b00, 1'b1, 4'b1111);
        cycle();
        chk("v032_rr2", {12'd0, out_valid}, 16'h0004);
        drive(1'b0, 4'h0, 2'b00, 1'b0, 4'b1111);
        cycle();

        // Stalled input re-steered from full ch3 to ch0
        drive(1'b1, 4'hC, 2'b11, 1'b0, 4'b0000);
        cycle();
        drive(1'b1, 4'h9, 2'b11, 1'b0, 4'b0000);
        cycle();
        drive(1'b1, 4'h9, 2'b00, 1'b0, 4'b0000);
        cycle();
        drive(1'b0, 4'h0, 2'b00, 1'b0, 4'b0000);
        chk("v033_valid", {12'd0, out_valid}, 16'h0009);
        chk("v033_ch0", {12'd0, out_data[3:0]}, 16'h0009);
        chk("v033_ch3", {12'd0, out_data[15:12]}, 16'h000C);
        out_ready = 4'b1111;
        cycle();

        // Pointer held across mode-0 accepts: next round-robin slot is ch3
        drive(1'b1, 4'hE, 2'b00, 1'b1, 4'b1111);
        cycle();
        drive(1'b0, 4'h0, 2'b00, 1'b0, 4'b1111);
        chk("rr_hold", {12'd0, out_valid}, 16'h0008);
        cycle();

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), W'($urandom), 2'($urandom), 1'($urandom_range(0, 1)),
                  4'($urandom));
            cycle();
        end
        drive(1'b0, 4'h0, 2'b00, 1'b0, 4'b1111);
        cycle();
        cycle();

        // Counter wrap
        n = 256 - int'(m_cnt);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, W'(i), 2'b00, 1'b1, 4'b1111);
            cycle();
        end
        drive(1'b0, 4'h0, 2'b00, 1'b0, 4'b1111);
        chk("wrap_count", {8'd0, xfer_count}, 16'h0000);
        cycle();

        // Fill all channels, then reset asynchronously between edges
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, W'(k + 4), 2'(k), 1'b0, 4'b0000);
            cycle();
        end
        drive(1'b1, 4'hF, 2'b11, 1'b0, 4'b0000);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", {12'd0, out_valid}, 16'h0000);
        chk("async_ready", {15'd0, in_ready}, 16'h0000);
        chk("async_count", {8'd0, xfer_count}, 16'h0000);
        cycle();
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", {15'd0, in_ready}, 16'h0001);
        cycle();
        drive(1'b0, 4'h0, 2'b00, 1'b0, 4'b0000);
        chk("post_rst_valid", {12'd0, out_valid}, 16'h0008);
        cycle();
        out_ready = 4'b1111;
        cycle();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
